// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: memory-op and hazard FSM types shared by the hazard controller.
package pipeline_hazard_ctrl_pkg;
    typedef enum logic [1:0] {MEM_NONE = 2'd0, MEM_READ = 2'd1, MEM_WRITE = 2'd2} memaccess_t;
    typedef enum logic [0:0] {HZD_RUN = 1'b0, HZD_MEM_WAIT = 1'b1} hzd_state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline-side hazard inputs and stall/flush controls.
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;
    memaccess_t memaccess_d;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic       uses_rs1_d;
    logic       uses_rs2_d;
    memaccess_t memaccess_e;
    logic [4:0] rd_e;
    logic       redirect_e;
    memaccess_t memaccess_m;
    logic       dmem_ready;
    logic       dmem_req;
    logic       stall_f;
    logic       stall_d;
    logic       stall_e;
    logic       stall_m;
    logic       flush_d;
    logic       flush_e;
    logic       flush_w;
    modport master (
        output memaccess_d, rs1_d, rs2_d, uses_rs1_d, uses_rs2_d, memaccess_e, rd_e,
               redirect_e, memaccess_m, dmem_ready,
        input  dmem_req, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w
    );
    modport slave (
        input  memaccess_d, rs1_d, rs2_d, uses_rs1_d, uses_rs2_d, memaccess_e, rd_e,
               redirect_e, memaccess_m, dmem_ready,
        output dmem_req, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_perf.sv
// hazard_perf_counters: three wrapping hazard event counters.
module hazard_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_inc_i,
    input  logic             loaduse_inc_i,
    input  logic             redirect_inc_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] loaduse_cnt_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);
    logic [CNT_W-1:0] stall_q, loaduse_q, redirect_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q    <= '0;
            loaduse_q  <= '0;
            redirect_q <= '0;
        end else begin
            stall_q    <= stall_q + CNT_W'(stall_inc_i);
            loaduse_q  <= loaduse_q + CNT_W'(loaduse_inc_i);
            redirect_q <= redirect_q + CNT_W'(redirect_inc_i);
        end
    end
    assign stall_cnt_o    = stall_q;
    assign loaduse_cnt_o  = loaduse_q;
    assign redirect_cnt_o = redirect_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for load-use, E-stage redirect and dmem waits.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  bus,
    output logic                   mem_timeout,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       loaduse_cnt,
    output logic [CNT_W-1:0]       redirect_cnt
);
    localparam logic [0:0] S_RUN  = HZD_RUN;
    localparam logic [0:0] S_WAIT = HZD_MEM_WAIT;

    logic [0:0]  state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic        timeout_q, timeout_d;
    logic        mem_stall, load_use, redir_ok, lu_ok;

    // Stores depending only on rs2 get their data forwarded W->M, so they never stall.
    assign load_use = bus.memaccess_e == MEM_READ && bus.rd_e != 5'd0 &&
                      ((bus.uses_rs1_d && bus.rs1_d == bus.rd_e) ||
                       (bus.uses_rs2_d && bus.rs2_d == bus.rd_e && bus.memaccess_d != MEM_WRITE));
    assign bus.dmem_req = bus.memaccess_m != MEM_NONE;
    assign mem_stall    = bus.dmem_req && !bus.dmem_ready;
    assign redir_ok     = bus.redirect_e && !mem_stall;
    assign lu_ok        = load_use && !bus.redirect_e && !mem_stall;

    assign bus.stall_f = rst_n && (mem_stall || lu_ok);
    assign bus.stall_d = rst_n && (mem_stall || lu_ok);
    assign bus.stall_e = rst_n && mem_stall;
    assign bus.stall_m = rst_n && mem_stall;
    assign bus.flush_w = rst_n && mem_stall;
    assign bus.flush_d = rst_n && redir_ok;
    assign bus.flush_e = rst_n && (redir_ok || lu_ok);

    always_comb begin
        state_d   = (state_q == S_RUN) ? (mem_stall ? S_WAIT : S_RUN)
                                       : ((bus.dmem_ready || !bus.dmem_req) ? S_RUN : S_WAIT);
        wait_d    = (state_d == S_WAIT) ? ((wait_q == 16'hFFFF) ? wait_q : wait_q + 16'd1) : 16'd0;
        timeout_d = timeout_q || (wait_d >= 16'(MAX_WAIT));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_RUN;
            wait_q    <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;

    hazard_perf_counters #(.CNT_W(CNT_W)) u_perf (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_inc_i    (mem_stall),
        .loaduse_inc_i  (lu_ok),
        .redirect_inc_i (redir_ok),
        .stall_cnt_o    (stall_cnt),
        .loaduse_cnt_o  (loaduse_cnt),
        .redirect_cnt_o (redirect_cnt)
    );
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RV32 pipeline. Combines load-use detection in D/E, branch/jump redirect from E and the data-memory request/ready handshake in M into per-stage stall and flush controls. Store operands that only hit through rs2 are forwarded W→M by the store-data forwarding path and are not stalled. Also keeps hazard performance counters and a sticky memory-timeout flag.

## Interface

- `MAX_WAIT`, default 255: dmem wait cycles tolerated before `mem_timeout` sets; range 1..65535.
- `CNT_W`, default 32: width of the performance counters.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `memaccess_d` in memaccess_t: memory op of the instruction in D.
- `rs1_d`, `rs2_d` in 5 each: source registers in D.
- `uses_rs1_d`, `uses_rs2_d` in 1 each: D instruction reads rs1 / rs2.
- `memaccess_e` in memaccess_t: memory op in E.
- `rd_e` in 5: destination in E.
- `redirect_e` in 1: taken branch or jump resolved in E.
- `memaccess_m` in memaccess_t: memory op in M.
- `dmem_ready` in 1: data memory accepts or completes the current access this cycle.
- `dmem_req` out 1: data-memory request valid.
- `stall_f`, `stall_d`, `stall_e`, `stall_m` out 1 each: hold the pipeline register feeding that stage.
- `flush_d`, `flush_e`, `flush_w` out 1 each: load a bubble into that stage's register.
- `mem_timeout` out 1: sticky; a wait exceeded `MAX_WAIT`.
- `stall_cnt`, `loaduse_cnt`, `redirect_cnt` out CNT_W each: performance counters.

## Operation

- FSM states: RUN and MEM_WAIT. Reset enters RUN.
- `dmem_req` = (memaccess_m != MEM_NONE). It is combinational and is held for every cycle an M access is outstanding.
- mem_stall = `dmem_req` && !`dmem_ready`.
- RUN → MEM_WAIT when mem_stall. MEM_WAIT → RUN on the cycle `dmem_ready`=1; that cycle is not a stall.
- Load-use = memaccess_e==MEM_READ && rd_e!=0 && ((uses_rs1_d && rs1_d==rd_e) || (uses_rs2_d && rs2_d==rd_e && memaccess_d!=MEM_WRITE)).
- A store whose only dependence is rs2 is exempt from load-use.
- Priority, highest first:
  - mem_stall: `stall_f`/`stall_d`/`stall_e`/`stall_m`=1 and `flush_w`=1. No other flush. Redirect and load-use are suppressed. Because E is frozen, `redirect_e` stays asserted and is serviced after the stall.
  - redirect_e: `flush_d`=1 and `flush_e`=1, no stalls. A simultaneous load-use is discarded, since the D instruction is squashed.
  - load-use: `stall_f`=1, `stall_d`=1, `flush_e`=1. This produces exactly one bubble because the load then moves to M.
  - otherwise all controls are 0.
- Wait counter (16 bit):
  - Clears on entry to RUN.
  - Increments each MEM_WAIT cycle and saturates.
  - When it reaches `MAX_WAIT`, `mem_timeout` sets. It clears only on reset, and it does not alter stall behaviour.
- Counters wrap modulo 2^CNT_W:
  - `stall_cnt` +1 per mem_stall cycle.
  - `loaduse_cnt` +1 per applied load-use bubble.
  - `redirect_cnt` +1 per applied redirect, i.e. one not suppressed by mem_stall.

## Timing

- All stall, flush and `dmem_req` outputs are combinational from current inputs and state. They take effect at the next rising edge, with zero added latency.
- Counters, the FSM, the wait counter and `mem_timeout` update on the rising edge.
- Reset values: state RUN, wait counter 0, `mem_timeout`=0, all counters 0.
- During reset, `stall_*`/`flush_*` are driven 0 and `dmem_req` follows `memaccess_m`. Reset mid-MEM_WAIT returns to RUN and clears `mem_timeout` in the same edge.
- A load with dmem_ready=0 for N cycles produces N stall cycles. With dmem_ready high in the first cycle it produces 0.

## Structure

- memaccess_t (MEM_NONE, MEM_READ, MEM_WRITE) already lives in riscv_defines.
- Add the FSM enum hzd_state_t {HZD_RUN, HZD_MEM_WAIT} to riscv_defines.
- One sub-module is natural: `hazard_perf_counters`, which holds the three wrapping counters with increment strobes, clk and rst_n.

## Test plan

- lw x5 in E, add using rs1=x5 in D → exactly one cycle with stall_f=stall_d=flush_e=1; loaduse_cnt=1.
- lw x5 in E, sw in D with rs2=x5, rs1=x6 → no stall. Same with rd_e=x0 and rs1=x0 → no stall.
- Load in M with dmem_ready low for 3 cycles → stall_f..m=1 and flush_w=1 for 3 cycles, FSM returns to RUN on the 4th; stall_cnt=3.
- redirect_e and load-use together → flush_d=flush_e=1, no stall; redirect_cnt=1, loaduse_cnt=0.
- redirect_e during a 2-cycle mem wait → no flush while stalled, flush_d/flush_e on the release cycle; redirect_cnt=1.
- MAX_WAIT=4, dmem_ready low for 6 cycles → mem_timeout rises after the 4th wait cycle and stays high until rst_n=0, which clears state and counters at the next edge.
